// File: rtl/periphery_pkg.sv
// periphery_pkg: shared widths, reset polarity and types for the periphery
// blocks. The input controller's state type, beat/word ratio and the parity
// helper used when IO_INPUT_PARITY_EN is defined live here.
package periphery_pkg;

    localparam int   INPUT_DATA_L       = 32;
    localparam int   INPUT_REG_L        = 128;
    localparam logic RESET_STATE        = 1'b0;
    localparam int   IO_MULTIPLE_FACTOR = INPUT_REG_L / INPUT_DATA_L;

    typedef enum logic [1:0] {
        IO_IN_IDLE,
        IO_IN_FILL,
        IO_IN_WRITE
    } io_in_state_t;

    // True when data plus its parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [INPUT_DATA_L-1:0] data,
                                            input logic                    par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: upstream controller for the input shift register.
// Accepts INPUT_DATA_L beats over valid/ready, forwards them to the shift
// register, and after every INPUT_REG_L/INPUT_DATA_L beats requests one
// memory write at an auto-incrementing word address.
// Optional feature macro: IO_INPUT_PARITY_EN adds in_par/par_err with a
// sticky even-parity error flag over accepted beats.
module io_input_ctrl #(
    parameter int INPUT_DATA_L = periphery_pkg::INPUT_DATA_L,
    parameter int INPUT_REG_L  = periphery_pkg::INPUT_REG_L,
    parameter int ADDR_L       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_L-1:0]       base_addr,
    input  logic [ADDR_L-1:0]       n_words,
    input  logic                    clr,
    input  logic [INPUT_DATA_L-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    shift_en,
    output logic [INPUT_DATA_L-1:0] shift_data,
    output logic                    wr_req,
    output logic [ADDR_L-1:0]       wr_addr,
    input  logic                    wr_gnt,
    output logic                    busy,
`ifdef IO_INPUT_PARITY_EN
    input  logic                    in_par,
    output logic                    par_err,
`endif
    output logic                    done
);

    import periphery_pkg::io_in_state_t;
    import periphery_pkg::IO_IN_IDLE;
    import periphery_pkg::IO_IN_FILL;
    import periphery_pkg::IO_IN_WRITE;
    import periphery_pkg::RESET_STATE;

    localparam int                MF        = INPUT_REG_L / INPUT_DATA_L;
    localparam int                CNT_W     = $clog2(MF);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MF - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_L-1:0] ADDR_ONE  = ADDR_L'(1);

    io_in_state_t      r_state;
    io_in_state_t      w_stateNext;
    logic [CNT_W-1:0]  r_beatCnt;
    logic [ADDR_L-1:0] r_addrQ;
    logic [ADDR_L-1:0] r_wordsLeft;
    logic              r_done;
    logic              w_doneNext;
    logic              w_inReady;
    logic              w_wrReq;
    logic              w_beatAccept;
    logic              w_grant;
    logic              w_startLoad;

    // State register; async reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_STATE) begin
            r_state <= IO_IN_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake decode; clr overrides everything and
    // suppresses ready, write request and done in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_inReady   = 1'b0;
        w_wrReq     = 1'b0;
        w_doneNext  = 1'b0;
        case (r_state)
            IO_IN_IDLE: begin
                if (start) begin
                    if (n_words == '0) begin
                        w_doneNext = 1'b1;
                    end else begin
                        w_stateNext = IO_IN_FILL;
                    end
                end
            end
            IO_IN_FILL: begin
                w_inReady = 1'b1;
                if (in_valid && (r_beatCnt == LAST_BEAT)) begin
                    w_stateNext = IO_IN_WRITE;
                end
            end
            IO_IN_WRITE: begin
                w_wrReq = 1'b1;
                if (wr_gnt) begin
                    if (r_wordsLeft == ADDR_ONE) begin
                        w_stateNext = IO_IN_IDLE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_stateNext = IO_IN_FILL;
                    end
                end
            end
            default: w_stateNext = IO_IN_IDLE;
        endcase
        if (clr) begin
            w_stateNext = IO_IN_IDLE;
            w_inReady   = 1'b0;
            w_wrReq     = 1'b0;
            w_doneNext  = 1'b0;
        end
    end

    assign w_beatAccept = in_valid & w_inReady;
    assign w_grant      = w_wrReq & wr_gnt;
    assign w_startLoad  = (r_state == IO_IN_IDLE) & start & ~clr;

    // Beat counter, word address and remaining-word count, plus the
    // registered done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_STATE) begin
            r_beatCnt   <= '0;
            r_addrQ     <= '0;
            r_wordsLeft <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_doneNext;
            if (clr) begin
                r_beatCnt <= '0;
            end else if (w_startLoad) begin
                r_beatCnt   <= '0;
                r_addrQ     <= base_addr;
                r_wordsLeft <= n_words;
            end else begin
                if (w_beatAccept) begin
                    r_beatCnt <= (r_beatCnt == LAST_BEAT) ? '0 : r_beatCnt + CNT_ONE;
                end
                if (w_grant) begin
                    r_addrQ     <= r_addrQ + ADDR_ONE;
                    r_wordsLeft <= r_wordsLeft - ADDR_ONE;
                end
            end
        end
    end

`ifdef IO_INPUT_PARITY_EN
    import periphery_pkg::even_parity_ok;

    logic r_parErr;

    // Sticky parity error over accepted beats, cleared when a new transfer starts.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_STATE) begin
            r_parErr <= 1'b0;
        end else if (w_startLoad) begin
            r_parErr <= 1'b0;
        end else if (w_beatAccept && !even_parity_ok(in_data, in_par)) begin
            r_parErr <= 1'b1;
        end
    end

    assign par_err = r_parErr;
`endif

    assign in_ready   = w_inReady;
    assign shift_en   = w_beatAccept;
    assign shift_data = in_data;
    assign wr_req     = w_wrReq;
    assign wr_addr    = r_addrQ;
    assign busy       = (r_state != IO_IN_IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: self-checking bench for io_input_ctrl. A downstream
// shift register and a stream/word model predict every write address and
// assembled word. Parity scenarios are compiled in with IO_INPUT_PARITY_EN.
module tb_io_input_ctrl;

    localparam int DW = periphery_pkg::INPUT_DATA_L;
    localparam int RW = periphery_pkg::INPUT_REG_L;
    localparam int MF = periphery_pkg::IO_MULTIPLE_FACTOR;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   base_addr;
    logic [15:0]   n_words;
    logic          clr;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic [DW-1:0] shift_data;
    logic          wr_req;
    logic [15:0]   wr_addr;
    logic          wr_gnt;
    logic          busy;
    logic          done;
`ifdef IO_INPUT_PARITY_EN
    logic          in_par;
    logic          par_err;
`endif

    int            nChecks = 0;
    int            nErrors = 0;

    int            wrCycQ[$];
    logic [15:0]   wrAddrQ[$];
    logic [RW-1:0] wrWordQ[$];
    logic [DW-1:0] beats[$];
    logic [RW-1:0] shreg = '0;
    int            ptr, reqCycles, shiftCnt, doneCnt, doneCyc, busyCycles, protoErr;
    int            badIdx = -1;

    io_input_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_words(n_words),
        .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .shift_en(shift_en), .shift_data(shift_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_gnt(wr_gnt), .busy(busy),
`ifdef IO_INPUT_PARITY_EN
        .in_par(in_par), .par_err(par_err),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // Word k is beats MF*k .. MF*k+MF-1 of the stream, first beat in the MS slice.
    function automatic logic [RW-1:0] expWord(input int k);
        logic [RW-1:0] w;
        w = '0;
        for (int i = 0; i < MF; i++) w = {w[RW-DW-1:0], beats[k*MF+i]};
        return w;
    endfunction

    // Runs one transfer as bus master/slave and records what the DUT did.
    // vMode: 0 valid always, 1 valid on odd cycles, 2 random 70%.
    // gDelay >= 0: grant after wr_req has been up gDelay cycles; < 0: random gPct.
    task automatic runXfer(input logic [15:0] base, input logic [15:0] n, input int vMode,
                           input int gDelay, input int gPct, input bit seqBeats,
                           input int clrCyc, input int reCyc, input int budget);
        int          reqRun;
        logic        prevReq;
        logic [15:0] prevAddr;
        wrCycQ.delete(); wrAddrQ.delete(); wrWordQ.delete(); beats.delete();
        ptr = 0; reqCycles = 0; shiftCnt = 0; doneCnt = 0; doneCyc = -1;
        busyCycles = 0; protoErr = 0; reqRun = 0; prevReq = 1'b0; prevAddr = '0;
        for (int cyc = 0; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            start     = (cyc == 0) || (cyc == reCyc);
            base_addr = (cyc == 0) ? base : base + 16'h0100;
            n_words   = (cyc == 0) ? n : 16'd5;
            clr       = (cyc == clrCyc);
            if (beats.size() <= ptr) beats.push_back(seqBeats ? DW'(ptr) : DW'($urandom()));
            in_data = beats[ptr];
`ifdef IO_INPUT_PARITY_EN
            in_par = (^in_data) ^ (ptr == badIdx);
`endif
            case (vMode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((cyc % 2) == 1);
                default: in_valid = ($urandom_range(99) < 70);
            endcase
            #1;
            if (gDelay < 0) begin
                wr_gnt = ($urandom_range(99) < gPct);
            end else if (wr_req) begin
                wr_gnt = (reqRun >= gDelay);
                reqRun++;
            end else begin
                wr_gnt = 1'b0;
                reqRun = 0;
            end
            @(negedge clk);
            if (busy) busyCycles++;
            if (done) begin doneCnt++; doneCyc = cyc; end
            if (shift_en !== (in_valid & in_ready)) protoErr++;
            if (shift_en && (shift_data !== in_data)) protoErr++;
            if (shift_en && !busy) protoErr++;
            if (wr_req && (in_ready || shift_en)) protoErr++;
            if (wr_req) begin
                reqCycles++;
                if (prevReq && (wr_addr !== prevAddr)) protoErr++;
            end
            if (shift_en) begin
                shreg = {shreg[RW-DW-1:0], in_data};
                ptr++;
                shiftCnt++;
            end
            if (wr_req && wr_gnt) begin
                wrCycQ.push_back(cyc);
                wrAddrQ.push_back(wr_addr);
                wrWordQ.push_back(shreg);
            end
            prevReq  = wr_req & ~wr_gnt;
            prevAddr = wr_addr;
            if ((doneCnt > 0) && (cyc >= doneCyc + 2)) break;
        end
        start = 1'b0; clr = 1'b0; in_valid = 1'b0; wr_gnt = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nChecks++;
        if ({wr_req, busy, done, in_ready, shift_en} !== 5'b0) begin
            nErrors++;
            $display("[TB] FAIL reset_ctrl got %b want 00000", {wr_req, busy, done, in_ready, shift_en});
        end
        nChecks++;
        if (wr_addr !== 16'h0) begin
            nErrors++;
            $display("[TB] FAIL reset_addr got %h want 0000", wr_addr);
        end
    endtask

    task automatic test_basic();
        runXfer(16'h0010, 16'd2, 0, 0, 0, 1'b1, -1, -1, 40);
        nChecks++;
        if (wrCycQ.size() != 2) begin
            nErrors++; $display("[TB] FAIL basic_nwr got %0d want 2", wrCycQ.size());
        end else begin
            nChecks++;
            if (wrCycQ[0] != 5 || wrCycQ[1] != 10) begin
                nErrors++; $display("[TB] FAIL basic_wrcyc got %0d/%0d want 5/10", wrCycQ[0], wrCycQ[1]);
            end
            for (int k = 0; k < 2; k++) begin
                nChecks++;
                if (wrAddrQ[k] !== 16'h0010 + 16'(k)) begin
                    nErrors++; $display("[TB] FAIL basic_addr%0d got %h want %h", k, wrAddrQ[k], 16'h0010 + 16'(k));
                end
                nChecks++;
                if (wrWordQ[k] !== expWord(k)) begin
                    nErrors++; $display("[TB] FAIL basic_word%0d got %h want %h", k, wrWordQ[k], expWord(k));
                end
            end
        end
        nChecks++;
        if (doneCnt != 1 || doneCyc != 11) begin
            nErrors++; $display("[TB] FAIL basic_done got cnt %0d cyc %0d want 1 at 11", doneCnt, doneCyc);
        end
        nChecks++;
        if (busyCycles != 10 || protoErr != 0) begin
            nErrors++; $display("[TB] FAIL basic_busy got busy %0d proto %0d want 10/0", busyCycles, protoErr);
        end
    endtask

    task automatic test_gnt_delay();
        runXfer(16'h0020, 16'd1, 0, 3, 0, 1'b0, -1, -1, 40);
        nChecks++;
        if (reqCycles != 4 || wrCycQ.size() != 1) begin
            nErrors++; $display("[TB] FAIL gnt_hold got req %0d wr %0d want 4/1", reqCycles, wrCycQ.size());
        end else begin
            nChecks++;
            if (wrAddrQ[0] !== 16'h0020 || wrWordQ[0] !== expWord(0)) begin
                nErrors++; $display("[TB] FAIL gnt_data got %h/%h want 0020/%h", wrAddrQ[0], wrWordQ[0], expWord(0));
            end
        end
        nChecks++;
        if (shiftCnt != MF || protoErr != 0 || doneCnt != 1) begin
            nErrors++; $display("[TB] FAIL gnt_consume got shifts %0d proto %0d done %0d want %0d/0/1", shiftCnt, protoErr, doneCnt, MF);
        end
    endtask

    task automatic test_valid_toggle();
        runXfer(16'h0030, 16'd1, 1, 0, 0, 1'b0, -1, -1, 40);
        nChecks++;
        if (shiftCnt != MF || wrCycQ.size() != 1) begin
            nErrors++; $display("[TB] FAIL toggle_cnt got shifts %0d wr %0d want %0d/1", shiftCnt, wrCycQ.size(), MF);
        end else begin
            nChecks++;
            if (wrCycQ[0] != 2 * MF || wrWordQ[0] !== expWord(0)) begin
                nErrors++; $display("[TB] FAIL toggle_wr got cyc %0d word %h want %0d/%h", wrCycQ[0], wrWordQ[0], 2 * MF, expWord(0));
            end
        end
        runXfer(16'h0031, 16'd1, 0, 0, 0, 1'b0, -1, -1, 40);
        nChecks++;
        if (wrCycQ.size() != 1 || wrCycQ[0] != 5 || wrWordQ[0] !== expWord(0)) begin
            nErrors++; $display("[TB] FAIL toggle_followup got nwr %0d word %h want 1 at 5 %h", wrCycQ.size(), shreg, expWord(0));
        end
    endtask

    task automatic test_addr_wrap();
        runXfer(16'hFFFF, 16'd2, 2, -1, 50, 1'b0, -1, -1, 200);
        nChecks++;
        if (wrAddrQ.size() != 2) begin
            nErrors++; $display("[TB] FAIL wrap_nwr got %0d want 2", wrAddrQ.size());
        end else begin
            nChecks++;
            if (wrAddrQ[0] !== 16'hFFFF || wrAddrQ[1] !== 16'h0000) begin
                nErrors++; $display("[TB] FAIL wrap_addr got %h/%h want ffff/0000", wrAddrQ[0], wrAddrQ[1]);
            end
            nChecks++;
            if (wrWordQ[1] !== expWord(1)) begin
                nErrors++; $display("[TB] FAIL wrap_word got %h want %h", wrWordQ[1], expWord(1));
            end
        end
    endtask

    task automatic test_zero_and_restart();
        runXfer(16'h0040, 16'd0, 0, 0, 0, 1'b0, -1, -1, 8);
        nChecks++;
        if (doneCnt != 1 || doneCyc != 1 || busyCycles != 0 || wrCycQ.size() != 0) begin
            nErrors++; $display("[TB] FAIL zero_words got done %0d@%0d busy %0d wr %0d want 1@1/0/0", doneCnt, doneCyc, busyCycles, wrCycQ.size());
        end
        runXfer(16'h0050, 16'd1, 0, 0, 0, 1'b0, -1, 3, 40);
        nChecks++;
        if (wrAddrQ.size() != 1 || doneCnt != 1) begin
            nErrors++; $display("[TB] FAIL restart_ignored got wr %0d done %0d want 1/1", wrAddrQ.size(), doneCnt);
        end else begin
            nChecks++;
            if (wrAddrQ[0] !== 16'h0050 || wrWordQ[0] !== expWord(0)) begin
                nErrors++; $display("[TB] FAIL restart_data got %h/%h want 0050/%h", wrAddrQ[0], wrWordQ[0], expWord(0));
            end
        end
    endtask

    task automatic test_clr();
        runXfer(16'h0100, 16'd1, 0, 0, 0, 1'b0, 3, -1, 8);
        nChecks++;
        if (shiftCnt != 2 || wrCycQ.size() != 0 || doneCnt != 0 || busyCycles != 3) begin
            nErrors++; $display("[TB] FAIL clr_abort got shifts %0d wr %0d done %0d busy %0d want 2/0/0/3", shiftCnt, wrCycQ.size(), doneCnt, busyCycles);
        end
        runXfer(16'h0200, 16'd1, 0, 0, 0, 1'b0, -1, -1, 40);
        nChecks++;
        if (wrCycQ.size() != 1) begin
            nErrors++; $display("[TB] FAIL clr_next_nwr got %0d want 1", wrCycQ.size());
        end else begin
            nChecks++;
            if (wrAddrQ[0] !== 16'h0200 || wrWordQ[0] !== expWord(0) || wrCycQ[0] != 5) begin
                nErrors++; $display("[TB] FAIL clr_next_word got %h/%h@%0d want 0200/%h@5", wrAddrQ[0], wrWordQ[0], wrCycQ[0], expWord(0));
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0300; n_words = 16'd1; in_valid = 1'b1; wr_gnt = 1'b0; in_data = DW'($urandom());
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < MF; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        nChecks++;
        if (wr_req !== 1'b1 || wr_addr !== 16'h0300) begin
            nErrors++; $display("[TB] FAIL arst_pre got req %b addr %h want 1/0300", wr_req, wr_addr);
        end
        rst = 1'b0;
        #1;
        nChecks++;
        if ({wr_req, busy, done, in_ready} !== 4'b0 || wr_addr !== 16'h0) begin
            nErrors++; $display("[TB] FAIL arst_now got %b addr %h want 0000/0000", {wr_req, busy, done, in_ready}, wr_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        nChecks++;
        if (busy !== 1'b0 || wr_req !== 1'b0) begin
            nErrors++; $display("[TB] FAIL arst_after got busy %b req %b want 0/0", busy, wr_req);
        end
    endtask

`ifdef IO_INPUT_PARITY_EN
    task automatic test_parity();
        badIdx = 2;
        runXfer(16'h0400, 16'd1, 0, 0, 0, 1'b0, -1, -1, 40);
        badIdx = -1;
        nChecks++;
        if (par_err !== 1'b1 || wrCycQ.size() != 1) begin
            nErrors++; $display("[TB] FAIL parity_set got %b wr %0d want 1/1", par_err, wrCycQ.size());
        end else begin
            nChecks++;
            if (wrWordQ[0] !== expWord(0)) begin
                nErrors++; $display("[TB] FAIL parity_data got %h want %h", wrWordQ[0], expWord(0));
            end
        end
        repeat (3) @(negedge clk);
        nChecks++;
        if (par_err !== 1'b1) begin
            nErrors++; $display("[TB] FAIL parity_sticky got %b want 1", par_err);
        end
        runXfer(16'h0410, 16'd1, 0, 0, 0, 1'b0, -1, -1, 40);
        nChecks++;
        if (par_err !== 1'b0) begin
            nErrors++; $display("[TB] FAIL parity_clear got %b want 0", par_err);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] base;
        logic [15:0] n;
        for (int t = 0; t < 6; t++) begin
            base = 16'($urandom());
            n    = 16'($urandom_range(4, 1));
            runXfer(base, n, 2, -1, 40, 1'b0, -1, -1, int'(n) * 60 + 20);
            nChecks++;
            if (wrAddrQ.size() != int'(n) || doneCnt != 1 || protoErr != 0) begin
                nErrors++; $display("[TB] FAIL rand%0d_count got wr %0d done %0d proto %0d want %0d/1/0", t, wrAddrQ.size(), doneCnt, protoErr, n);
            end
            for (int k = 0; k < wrAddrQ.size(); k++) begin
                nChecks++;
                if (wrAddrQ[k] !== base + 16'(k) || wrWordQ[k] !== expWord(k)) begin
                    nErrors++; $display("[TB] FAIL rand%0d_wr%0d got %h/%h want %h/%h", t, k, wrAddrQ[k], wrWordQ[k], base + 16'(k), expWord(k));
                end
            end
        end
    endtask

    // Scenario sequence, then the single summary line.
    initial begin
        rst = 1'b0; start = 1'b0; clr = 1'b0; base_addr = '0; n_words = '0;
        in_data = '0; in_valid = 1'b0; wr_gnt = 1'b0;
`ifdef IO_INPUT_PARITY_EN
        in_par = 1'b0;
`endif
        repeat (2) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        test_basic();
        test_gnt_delay();
        test_valid_toggle();
        test_addr_wrap();
        test_zero_and_restart();
        test_clr();
        test_async_reset();
`ifdef IO_INPUT_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
